// File: rtl/vgpr_arb_pkg.sv
// Shared types and constants for the VGPR write-port arbiter.
// The optional starvation override is enabled by VGPR_WR_ARB_STARVE_EN.
package vgpr_arb_pkg;

    localparam int NUM_PORTS = 9;
    localparam int SEL_W     = 16;
    localparam int LEN_W     = 2;
    localparam int MAX_WAIT  = 15;
    localparam int PTR_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Reduce a sum of two port indices (each 0..8) back into 0..8.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] sum);
        if (sum >= (PTR_W+1)'(NUM_PORTS))
            return PTR_W'(sum - (PTR_W+1)'(NUM_PORTS));
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/vgpr_wr_port_arbiter_rr_pick9.sv
// Combinational round-robin picker: first set request scanning from ptr
// upwards, wrapping after port 8.
module rr_pick9
    import vgpr_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] winner_oh,
    output logic [PTR_W-1:0]     winner_idx,
    output logic                 valid
);

    logic [PTR_W-1:0]     ptr_safe;
    logic [NUM_PORTS-1:0] req_rot;
    logic [PTR_W-1:0]     offset;

    // Pointer values 9..15 never occur; fold them to 0 so indexing stays in range.
    assign ptr_safe = (ptr >= PTR_W'(NUM_PORTS)) ? '0 : ptr;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            assign req_rot[gi]   = req[wrap_idx({1'b0, ptr_safe} + (PTR_W+1)'(gi))];
            assign winner_oh[gi] = valid && (winner_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_rot[k])
                offset = PTR_W'(k);
        end
    end

    assign valid      = |req;
    assign winner_idx = wrap_idx({1'b0, ptr_safe} + {1'b0, offset});

endmodule

// File: rtl/vgpr_wr_port_arbiter.sv
// Round-robin burst arbiter for the shared VGPR write port (9 requesters).
// Define VGPR_WR_ARB_STARVE_EN to add per-port wait counters and starve_flag.
module vgpr_wr_port_arbiter
    import vgpr_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       port_req,
    input  logic [NUM_PORTS*LEN_W-1:0] port_len,
    output logic [NUM_PORTS-1:0]       port_gnt,
    output logic                       port_gnt_last,
    output logic [SEL_W-1:0]           wr_port_select,
    output logic                       arb_busy
`ifdef VGPR_WR_ARB_STARVE_EN
    ,
    output logic                       starve_flag
`endif
);

    arb_state_t           state_reg;
    logic [NUM_PORTS-1:0] gnt_reg;
    logic [PTR_W-1:0]     idx_reg;
    logic [LEN_W-1:0]     cnt_reg;
    logic [PTR_W-1:0]     rr_ptr_reg;

    logic                 arb_now;
    logic [PTR_W-1:0]     ptr_after_w;
    logic [PTR_W-1:0]     pick_ptr;
    logic [NUM_PORTS-1:0] rr_oh;
    logic [PTR_W-1:0]     rr_idx;
    logic                 rr_valid;
    logic [NUM_PORTS-1:0] win_oh;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_valid;
    logic [LEN_W-1:0]     win_len;

    // Arbitrate when idle, or on the final beat so the next owner follows with no bubble.
    assign arb_now     = (state_reg == IDLE) || (cnt_reg == '0);
    assign ptr_after_w = wrap_idx({1'b0, idx_reg} + (PTR_W+1)'(1));
    // During a burst the current owner is scanned last, so it only wins again when alone.
    assign pick_ptr    = (state_reg == GRANT) ? ptr_after_w : rr_ptr_reg;

    rr_pick9 u_pick (
        .req        (port_req),
        .ptr        (pick_ptr),
        .winner_oh  (rr_oh),
        .winner_idx (rr_idx),
        .valid      (rr_valid)
    );

`ifdef VGPR_WR_ARB_STARVE_EN
    logic [NUM_PORTS-1:0] starve_vec;
    logic [PTR_W-1:0]     starve_idx;
    logic                 starve_override;
    logic                 starve_flag_reg;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wait
            logic [3:0] wait_reg;

            always_ff @(posedge clk) begin
                if (rst)
                    wait_reg <= '0;
                else if (gnt_reg[gi])
                    wait_reg <= '0;
                else if (port_req[gi] && (wait_reg != 4'hF))
                    wait_reg <= wait_reg + 4'd1;
            end

            assign starve_vec[gi] = port_req[gi] && !gnt_reg[gi] && (wait_reg >= 4'(MAX_WAIT));
        end
    endgenerate

    always_comb begin
        starve_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (starve_vec[k])
                starve_idx = PTR_W'(k);
        end
    end

    // Flag only when the starvation rule actually changes the winner.
    assign starve_override = (|starve_vec) && (starve_idx != rr_idx);

    always_comb begin
        win_idx = rr_idx;
        win_oh  = rr_oh;
        if (|starve_vec) begin
            win_idx             = starve_idx;
            win_oh              = '0;
            win_oh[starve_idx]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve_flag_reg <= 1'b0;
        else
            starve_flag_reg <= arb_now && starve_override;
    end

    assign starve_flag = starve_flag_reg;
`else
    assign win_idx = rr_idx;
    assign win_oh  = rr_oh;
`endif

    assign win_valid = rr_valid;
    assign win_len   = port_len[win_idx*LEN_W +: LEN_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            rr_ptr_reg <= '0;
        end else if (arb_now) begin
            if (state_reg == GRANT)
                rr_ptr_reg <= ptr_after_w;
            if (win_valid) begin
                state_reg <= GRANT;
                gnt_reg   <= win_oh;
                idx_reg   <= win_idx;
                cnt_reg   <= win_len;
            end else begin
                state_reg <= IDLE;
                gnt_reg   <= '0;
            end
        end else begin
            cnt_reg <= cnt_reg - LEN_W'(1);
        end
    end

    assign port_gnt       = gnt_reg;
    assign wr_port_select = {(SEL_W-NUM_PORTS)'(0), gnt_reg};
    assign arb_busy       = (state_reg == GRANT);
    assign port_gnt_last  = arb_busy && (cnt_reg == '0);

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Self-checking bench for vgpr_wr_port_arbiter: scenario tasks with a queue of
// expected per-cycle select/last/busy values.
module tb_vgpr_wr_port_arbiter;
    import vgpr_arb_pkg::*;

    logic                       clk;
    logic                       rst;
    logic [NUM_PORTS-1:0]       port_req;
    logic [NUM_PORTS*LEN_W-1:0] port_len;
    logic [NUM_PORTS-1:0]       port_gnt;
    logic                       port_gnt_last;
    logic [SEL_W-1:0]           wr_port_select;
    logic                       arb_busy;
`ifdef VGPR_WR_ARB_STARVE_EN
    logic                       starve_flag;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] sel;
        logic        last;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    vgpr_wr_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .port_req       (port_req),
        .port_len       (port_len),
        .port_gnt       (port_gnt),
        .port_gnt_last  (port_gnt_last),
        .wr_port_select (wr_port_select),
        .arb_busy       (arb_busy)
`ifdef VGPR_WR_ARB_STARVE_EN
        ,
        .starve_flag    (starve_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input logic [15:0] s, input logic l, input logic b);
        exp_q.push_back('{sel: s, last: l, busy: b});
    endfunction

    task automatic test_reset;
        rst      = 1'b1;
        port_req = 9'h1FF;
        port_len = '0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (wr_port_select !== 16'h0000 || port_gnt !== 9'h000 || arb_busy !== 1'b0 || port_gnt_last !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d sel=%h gnt=%h busy=%b last=%b expected all zero",
                         i, wr_port_select, port_gnt, arb_busy, port_gnt_last);
            end
        end
        rst = 1'b0;
        tick;
        checks++;
        if (wr_port_select !== 16'h0001 || port_gnt !== 9'h001) begin
            failures++;
            $display("FAIL reset_first_grant sel=%h gnt=%h expected sel=0001", wr_port_select, port_gnt);
        end
        $display("reset: first grant sel=%h", wr_port_select);
    endtask

    task automatic test_round_robin;
        exp_t e;
        for (int k = 1; k < NUM_PORTS; k++)
            push_exp(16'(1 << k), 1'b1, 1'b1);
        push_exp(16'h0001, 1'b1, 1'b1);
        push_exp(16'h0002, 1'b1, 1'b1);
        push_exp(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            tick;
            e = exp_q.pop_front();
            $display("rr cyc%0d sel=%h last=%b busy=%b", i, wr_port_select, port_gnt_last, arb_busy);
            checks++;
            if (wr_port_select !== e.sel || port_gnt !== e.sel[8:0]) begin
                failures++;
                $display("FAIL rr_sel cyc%0d sel=%h gnt=%h expected %h", i, wr_port_select, port_gnt, e.sel);
            end
            checks++;
            if (port_gnt_last !== e.last || arb_busy !== e.busy) begin
                failures++;
                $display("FAIL rr_flags cyc%0d last=%b busy=%b expected %b %b", i, port_gnt_last, arb_busy, e.last, e.busy);
            end
            if (i == 9) port_req = '0;
        end
    endtask

    task automatic test_burst;
        exp_t e;
        port_req = 9'h010;
        port_len[4*LEN_W +: LEN_W] = 2'd3;
        push_exp(16'h0010, 1'b0, 1'b1);
        push_exp(16'h0010, 1'b0, 1'b1);
        push_exp(16'h0010, 1'b0, 1'b1);
        push_exp(16'h0010, 1'b1, 1'b1);
        push_exp(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            e = exp_q.pop_front();
            $display("burst cyc%0d sel=%h last=%b busy=%b", i, wr_port_select, port_gnt_last, arb_busy);
            checks++;
            if (wr_port_select !== e.sel || port_gnt !== e.sel[8:0]) begin
                failures++;
                $display("FAIL burst_sel cyc%0d sel=%h gnt=%h expected %h", i, wr_port_select, port_gnt, e.sel);
            end
            checks++;
            if (port_gnt_last !== e.last || arb_busy !== e.busy) begin
                failures++;
                $display("FAIL burst_flags cyc%0d last=%b busy=%b expected %b %b", i, port_gnt_last, arb_busy, e.last, e.busy);
            end
            if (i == 0) port_len[4*LEN_W +: LEN_W] = 2'd0;
            if (i == 3) port_req = '0;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        port_len = '0;
        port_len[2*LEN_W +: LEN_W] = 2'd1;
        port_len[7*LEN_W +: LEN_W] = 2'd1;
        port_req = 9'h004;
        push_exp(16'h0004, 1'b0, 1'b1);
        push_exp(16'h0004, 1'b1, 1'b1);
        push_exp(16'h0080, 1'b0, 1'b1);
        push_exp(16'h0080, 1'b1, 1'b1);
        push_exp(16'h0004, 1'b0, 1'b1);
        push_exp(16'h0004, 1'b1, 1'b1);
        push_exp(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick;
            e = exp_q.pop_front();
            $display("b2b cyc%0d sel=%h last=%b busy=%b", i, wr_port_select, port_gnt_last, arb_busy);
            checks++;
            if (wr_port_select !== e.sel || port_gnt !== e.sel[8:0]) begin
                failures++;
                $display("FAIL b2b_sel cyc%0d sel=%h gnt=%h expected %h", i, wr_port_select, port_gnt, e.sel);
            end
            checks++;
            if (port_gnt_last !== e.last || arb_busy !== e.busy) begin
                failures++;
                $display("FAIL b2b_flags cyc%0d last=%b busy=%b expected %b %b", i, port_gnt_last, arb_busy, e.last, e.busy);
            end
            case (i)
                0: port_req = 9'h084;
                1: port_req = 9'h080;
                2: port_req = 9'h084;
                3: port_req = 9'h004;
                5: port_req = 9'h000;
                default: ;
            endcase
        end
    endtask

    task automatic test_single_continuous;
        exp_t e;
        port_len = '0;
        port_len[6*LEN_W +: LEN_W] = 2'd1;
        port_req = 9'h040;
        for (int k = 0; k < 3; k++) begin
            push_exp(16'h0040, 1'b0, 1'b1);
            push_exp(16'h0040, 1'b1, 1'b1);
        end
        push_exp(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick;
            e = exp_q.pop_front();
            $display("single cyc%0d sel=%h last=%b busy=%b", i, wr_port_select, port_gnt_last, arb_busy);
            checks++;
            if (wr_port_select !== e.sel || port_gnt !== e.sel[8:0]) begin
                failures++;
                $display("FAIL single_sel cyc%0d sel=%h gnt=%h expected %h", i, wr_port_select, port_gnt, e.sel);
            end
            checks++;
            if (port_gnt_last !== e.last || arb_busy !== e.busy) begin
                failures++;
                $display("FAIL single_flags cyc%0d last=%b busy=%b expected %b %b", i, port_gnt_last, arb_busy, e.last, e.busy);
            end
            if (i == 5) port_req = '0;
        end
    endtask

    task automatic test_mid_burst_reset;
        exp_t e;
        port_len = '0;
        port_len[8*LEN_W +: LEN_W] = 2'd3;
        port_req = 9'h100;
        push_exp(16'h0100, 1'b0, 1'b1);
        push_exp(16'h0100, 1'b0, 1'b1);
        push_exp(16'h0000, 1'b0, 1'b0);
        // Ports 3 and 8 both request after reset: a cleared pointer must pick 3.
        push_exp(16'h0008, 1'b1, 1'b1);
        push_exp(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            e = exp_q.pop_front();
            $display("midrst cyc%0d sel=%h last=%b busy=%b", i, wr_port_select, port_gnt_last, arb_busy);
            checks++;
            if (wr_port_select !== e.sel || port_gnt !== e.sel[8:0]) begin
                failures++;
                $display("FAIL midrst_sel cyc%0d sel=%h gnt=%h expected %h", i, wr_port_select, port_gnt, e.sel);
            end
            checks++;
            if (port_gnt_last !== e.last || arb_busy !== e.busy) begin
                failures++;
                $display("FAIL midrst_flags cyc%0d last=%b busy=%b expected %b %b", i, port_gnt_last, arb_busy, e.last, e.busy);
            end
            case (i)
                1: rst = 1'b1;
                2: begin
                    rst      = 1'b0;
                    port_req = 9'h108;
                end
                3: port_req = 9'h000;
                default: ;
            endcase
        end
    endtask

`ifdef VGPR_WR_ARB_STARVE_EN
    task automatic test_starve;
        int owner [6] = '{0, 1, 2, 3, 4, 0};
        logic [15:0] exp_sel;
        logic        exp_flag;
        rst      = 1'b1;
        port_req = 9'h1FF;
        port_len = '1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick;
            exp_sel  = 16'(1 << owner[i/4]);
            exp_flag = (i == 20);
            $display("starve cyc%0d sel=%h flag=%b", i, wr_port_select, starve_flag);
            checks++;
            if (wr_port_select !== exp_sel) begin
                failures++;
                $display("FAIL starve_sel cyc%0d sel=%h expected %h", i, wr_port_select, exp_sel);
            end
            checks++;
            if (starve_flag !== exp_flag) begin
                failures++;
                $display("FAIL starve_flag cyc%0d flag=%b expected %b", i, starve_flag, exp_flag);
            end
        end
        port_req = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        port_req = '0;
        port_len = '0;
        test_reset;
        test_round_robin;
        test_burst;
        test_back_to_back;
        test_single_continuous;
        test_mid_burst_reset;
`ifdef VGPR_WR_ARB_STARVE_EN
        test_starve;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
